// File: rtl/emergency_scheduler_if.sv
// Signal bundle between the emergency scheduler and its surroundings.
// master = the side that drives tick/emergencyLane, slave = the scheduler.
interface emergency_scheduler_if;
  logic       tick;
  logic [7:0] emergencyLane;
  logic [7:0] laneGreen;
  logic [7:0] laneYellow;
  logic [1:0] activeGroup;
  logic       busy;
  logic       loadCommand;
  logic [6:0] loadTime;

  modport master (
    output tick, emergencyLane,
    input  laneGreen, laneYellow, activeGroup, busy, loadCommand, loadTime
  );

  modport slave (
    input  tick, emergencyLane,
    output laneGreen, laneYellow, activeGroup, busy, loadCommand, loadTime
  );
endinterface

// File: rtl/emergency_scheduler.sv
// Emergency-vehicle scheduler for 8 lanes grouped into 4 approach pairs.
// Latches rising-edge requests per group, arbitrates among pending groups,
// runs each grant through all-red / green / yellow, then pulses a reload
// command so the main light controller resumes with a fresh phase timer.
//
// Optional build macro: EMERGENCY_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest-index pending group wins (no pointer)
//   undefined -> round-robin starting after the last granted group
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | lights belong to the main controller, waiting for a request
// S_ALLRED | all-red clearance before a grant (CLEAR_TIME ticks)
// S_GREEN  | granted pair green (GREEN_TIME ticks)
// S_YELLOW | granted pair yellow (YELLOW_TIME ticks)
// S_RESUME | single-cycle reload pulse to the main controller
module emergency_scheduler #(
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 5,
  parameter int CLEAR_TIME  = 2,
  parameter int RESUME_TIME = 5
) (
  input logic                  clk,
  input logic                  reset,
  emergency_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLRED,
    S_GREEN,
    S_YELLOW,
    S_RESUME
  } state_t;

  // Timers are loaded with duration-1 so a state lasts exactly N ticks.
  localparam logic [6:0] CLEAR_LD  = 7'(CLEAR_TIME - 1);
  localparam logic [6:0] GREEN_LD  = 7'(GREEN_TIME - 1);
  localparam logic [6:0] YELLOW_LD = 7'(YELLOW_TIME - 1);
  localparam logic [6:0] RESUME_LD = 7'(RESUME_TIME);

  state_t     r_state;
  logic [6:0] r_timer;
  logic [3:0] r_pend;
  logic [3:0] r_prev_req;
  logic [1:0] r_active;
  logic [7:0] r_green;
  logic [7:0] r_yellow;
  logic       r_busy;
  logic       r_load_cmd;
  logic [6:0] r_load_time;
`ifndef EMERGENCY_FIXED_PRIO_EN
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
`endif

  state_t     w_state_nxt;
  logic [6:0] w_timer_nxt;
  logic [3:0] w_pend_nxt;
  logic [1:0] w_active_nxt;
  logic [3:0] w_req;
  logic [3:0] w_rise;
  logic [1:0] w_grant_grp;
  logic       w_done;
  logic [7:0] w_green_nxt;
  logic [7:0] w_yellow_nxt;
  logic       w_busy_nxt;
  logic       w_load_cmd_nxt;
  logic [6:0] w_load_time_nxt;

  function automatic logic [7:0] grp_mask(logic [1:0] g);
    grp_mask = 8'h03 << {g, 1'b0};
  endfunction

`ifdef EMERGENCY_FIXED_PRIO_EN
  function automatic logic [1:0] pick_grp(logic [3:0] pend);
    pick_grp = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend[k]) pick_grp = 2'(k);
    end
  endfunction

  assign w_grant_grp = pick_grp(r_pend);
`else
  // Scan ptr+4 down to ptr+1 so the closest group after ptr is the last hit.
  function automatic logic [1:0] pick_grp(logic [3:0] pend, logic [1:0] ptr);
    logic [1:0] idx;
    pick_grp = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) pick_grp = idx;
    end
  endfunction

  assign w_grant_grp = pick_grp(r_pend, r_ptr);
`endif

  assign w_req  = {bus.emergencyLane[7] | bus.emergencyLane[6],
                   bus.emergencyLane[5] | bus.emergencyLane[4],
                   bus.emergencyLane[3] | bus.emergencyLane[2],
                   bus.emergencyLane[1] | bus.emergencyLane[0]};
  assign w_rise = w_req & ~r_prev_req;
  assign w_done = (r_timer == 7'd0) && bus.tick;

  // Next-state, timer, pending-set and grant decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_pend_nxt   = r_pend | w_rise;
    w_active_nxt = r_active;
`ifndef EMERGENCY_FIXED_PRIO_EN
    w_ptr_nxt    = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = 7'd0;
        if (r_pend != 4'd0) begin
          w_state_nxt = S_ALLRED;
          w_timer_nxt = CLEAR_LD;
        end
      end
      S_ALLRED: begin
        if (w_done) begin
          w_state_nxt  = S_GREEN;
          w_timer_nxt  = GREEN_LD;
          w_active_nxt = w_grant_grp;
          // Clearing after the set lets a same-cycle re-request be dropped.
          w_pend_nxt   = w_pend_nxt & ~(4'b0001 << w_grant_grp);
`ifndef EMERGENCY_FIXED_PRIO_EN
          w_ptr_nxt    = w_grant_grp;
`endif
        end else if (bus.tick) begin
          w_timer_nxt = r_timer - 7'd1;
        end
      end
      S_GREEN: begin
        if (w_done) begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = YELLOW_LD;
        end else if (bus.tick) begin
          w_timer_nxt = r_timer - 7'd1;
        end
      end
      S_YELLOW: begin
        if (w_done) begin
          if (r_pend != 4'd0) begin
            w_state_nxt = S_ALLRED;
            w_timer_nxt = CLEAR_LD;
          end else begin
            w_state_nxt = S_RESUME;
            w_timer_nxt = 7'd0;
          end
        end else if (bus.tick) begin
          w_timer_nxt = r_timer - 7'd1;
        end
      end
      S_RESUME: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 7'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 7'd0;
      end
    endcase
  end

  // Output values for the state being entered, so outputs switch on the transition edge.
  always_comb begin
    w_green_nxt     = 8'd0;
    w_yellow_nxt    = 8'd0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_load_cmd_nxt  = 1'b0;
    w_load_time_nxt = 7'd0;
    case (w_state_nxt)
      S_GREEN:  w_green_nxt  = grp_mask(w_active_nxt);
      S_YELLOW: w_yellow_nxt = grp_mask(w_active_nxt);
      S_RESUME: begin
        w_load_cmd_nxt  = 1'b1;
        w_load_time_nxt = RESUME_LD;
      end
      default: ;
    endcase
  end

  // State, bookkeeping and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= 7'd0;
      r_pend      <= 4'd0;
      r_prev_req  <= 4'd0;
      r_active    <= 2'd0;
      r_green     <= 8'd0;
      r_yellow    <= 8'd0;
      r_busy      <= 1'b0;
      r_load_cmd  <= 1'b0;
      r_load_time <= 7'd0;
`ifndef EMERGENCY_FIXED_PRIO_EN
      r_ptr       <= 2'd3;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_pend      <= w_pend_nxt;
      r_prev_req  <= w_req;
      r_active    <= w_active_nxt;
      r_green     <= w_green_nxt;
      r_yellow    <= w_yellow_nxt;
      r_busy      <= w_busy_nxt;
      r_load_cmd  <= w_load_cmd_nxt;
      r_load_time <= w_load_time_nxt;
`ifndef EMERGENCY_FIXED_PRIO_EN
      r_ptr       <= w_ptr_nxt;
`endif
    end
  end

  assign bus.laneGreen   = r_green;
  assign bus.laneYellow  = r_yellow;
  assign bus.activeGroup = r_active;
  assign bus.busy        = r_busy;
  assign bus.loadCommand = r_load_cmd;
  assign bus.loadTime    = r_load_time;

endmodule

// File: tb/tb_emergency_scheduler.sv
// Bench for emergency_scheduler: a sequential reference model of the
// service flow, a per-cycle output compare, and directed scenarios whose
// cycle counts and grant order are checked against hand-computed values.
module tb_emergency_scheduler;
  localparam int GREEN_T  = 20;
  localparam int YELLOW_T = 5;
  localparam int CLEAR_T  = 2;
  localparam int RESUME_T = 5;

  logic clk = 1'b0;
  logic reset;
  emergency_scheduler_if bus();

  emergency_scheduler #(
    .GREEN_TIME (GREEN_T),
    .YELLOW_TIME(YELLOW_T),
    .CLEAR_TIME (CLEAR_T),
    .RESUME_TIME(RESUME_T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int tick_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_pend, m_pb, m_prev;
  logic [1:0] m_ptr;
  bit         m_tick;
  logic [7:0] exp_green, exp_yellow;
  logic [1:0] exp_grp;
  logic       exp_busy, exp_load;
  logic [6:0] exp_ltime;

  function automatic logic [1:0] m_pick(input logic [3:0] p);
`ifdef EMERGENCY_FIXED_PRIO_EN
    for (int g = 0; g < 4; g++) if (p[g]) return 2'(g);
    return 2'd0;
`else
    for (int k = 1; k <= 4; k++) begin
      int g;
      g = (int'(m_ptr) + k) % 4;
      if (p[g]) return 2'(g);
    end
    return m_ptr;
`endif
  endfunction

  // One clock edge: latch new requests; a reset edge wipes everything.
  task automatic m_edge(output bit rst);
    logic [3:0] req;
    @(posedge clk);
    m_tick = bus.tick;
    m_pb   = m_pend;
    for (int g = 0; g < 4; g++) req[g] = bus.emergencyLane[2*g] | bus.emergencyLane[2*g+1];
    if (reset) begin
      m_pend = 4'd0; m_prev = 4'd0; m_ptr = 2'd3;
      exp_green = 8'd0; exp_yellow = 8'd0; exp_grp = 2'd0;
      exp_busy = 1'b0; exp_load = 1'b0; exp_ltime = 7'd0;
      rst = 1'b1;
    end else begin
      m_pend = m_pend | (req & ~m_prev);
      m_prev = req;
      rst = 1'b0;
    end
  endtask

  // Returns just after the edge carrying the n-th tick.
  task automatic m_ticks(input int n, output bit ab);
    int seen = 0;
    ab = 1'b0;
    while (seen < n) begin
      m_edge(ab);
      if (ab) return;
      if (m_tick) seen++;
    end
  endtask

  task automatic m_serve();
    bit ab;
    logic [1:0] g;
    forever begin
      exp_busy = 1'b1; exp_green = 8'd0; exp_yellow = 8'd0; exp_load = 1'b0; exp_ltime = 7'd0;
      m_ticks(CLEAR_T, ab);
      if (ab) return;
      g = m_pick(m_pb);
      m_pend[g] = 1'b0;
      m_ptr = g;
      exp_grp = g;
      exp_green = 8'h03 << (2*g);
      m_ticks(GREEN_T, ab);
      if (ab) return;
      exp_green = 8'd0;
      exp_yellow = 8'h03 << (2*g);
      m_ticks(YELLOW_T, ab);
      if (ab) return;
      exp_yellow = 8'd0;
      if (m_pb == 4'd0) begin
        exp_load = 1'b1;
        exp_ltime = 7'(RESUME_T);
        m_edge(ab);
        return;
      end
    end
  endtask

  initial begin
    bit ab;
    m_pend = 4'd0; m_prev = 4'd0; m_pb = 4'd0; m_ptr = 2'd3; exp_grp = 2'd0;
    forever begin
      exp_green = 8'd0; exp_yellow = 8'd0; exp_busy = 1'b0; exp_load = 1'b0; exp_ltime = 7'd0;
      m_edge(ab);
      if (!ab && m_pb != 4'd0) m_serve();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("laneGreen",   bus.laneGreen,   exp_green);
      chk("laneYellow",  bus.laneYellow,  exp_yellow);
      chk("activeGroup", bus.activeGroup, exp_grp);
      chk("busy",        bus.busy,        exp_busy);
      chk("loadCommand", bus.loadCommand, exp_load);
      chk("loadTime",    bus.loadTime,    exp_ltime);
    end
  end

  // ---------------- activity monitor ----------------
  int cnt_green = 0, cnt_yel = 0, cnt_red = 0, cnt_load = 0, cnt_busy = 0;
  logic [6:0] last_ltime = 7'd0;
  logic [7:0] q_green[$];
  bit mon_prev_g = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.laneGreen != 8'd0 && !mon_prev_g) q_green.push_back(bus.laneGreen);
      mon_prev_g = (bus.laneGreen != 8'd0);
      if (bus.laneGreen != 8'd0) cnt_green++;
      if (bus.laneYellow != 8'd0) cnt_yel++;
      if (bus.busy && bus.laneGreen == 8'd0 && bus.laneYellow == 8'd0 && !bus.loadCommand) cnt_red++;
      if (bus.loadCommand) begin cnt_load++; last_ltime = bus.loadTime; end
      if (bus.busy) cnt_busy++;
    end
  end

  // ---------------- tick generator ----------------
  int tcnt = 0;
  initial begin
    bus.tick = 1'b1;
    forever begin
      @(negedge clk);
      tcnt++;
      case (tick_mode)
        0:       bus.tick = 1'b1;
        1:       bus.tick = (tcnt % 4 == 0);
        default: bus.tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  int s_green, s_yel, s_red, s_load, s_busy, s_q;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_green = cnt_green; s_yel = cnt_yel; s_red = cnt_red;
    s_load = cnt_load; s_busy = cnt_busy; s_q = q_green.size();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lanes);
    bus.emergencyLane = lanes;
    cyc(1);
    bus.emergencyLane = 8'd0;
  endtask

  task automatic wait_quiet(input int maxc);
    int q = 0, n = 0;
    while (q < 3 && n < maxc) begin
      @(negedge clk);
      n++;
      if (bus.busy == 1'b0 && exp_busy == 1'b0 && m_pend == 4'd0) q++;
      else q = 0;
    end
    if (q < 3) chk("quiet_timeout", q, 3);
  endtask

  task automatic wait_green(input int maxc);
    int n = 0;
    while (bus.laneGreen == 8'd0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) chk("green_timeout", n, 0);
  endtask

  logic [7:0] rr_second, rr_third;

  initial begin
    reset = 1'b1;
    bus.emergencyLane = 8'($urandom);
    cyc(1);
    chk_en = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_green", bus.laneGreen, 0);
    bus.emergencyLane = 8'($urandom);
    cyc(1);
    bus.emergencyLane = 8'($urandom);
    cyc(1);
    chk("rst_load", bus.loadCommand, 0);
    reset = 1'b0;
    bus.emergencyLane = 8'd0;
    cyc(1);
    chk("post_rst_busy", bus.busy, 0);

    // single pulse on lane 3 -> group 1
    snap();
    pulse(8'h08);
    wait_quiet(500);
    chk("s1_green_cycles", cnt_green - s_green, 20);
    chk("s1_green_value",  q_green[s_q], 8'h0C);
    chk("s1_yellow_cycles", cnt_yel - s_yel, 5);
    chk("s1_allred_cycles", cnt_red - s_red, 2);
    chk("s1_load_pulses", cnt_load - s_load, 1);
    chk("s1_load_time", last_ltime, 5);
    chk("s1_busy_cycles", cnt_busy - s_busy, 28);

    // lanes 0 and 6 together from fresh reset
    do_reset(2);
    snap();
    pulse(8'h41);
    wait_quiet(500);
    chk("s2_grants", q_green.size() - s_q, 2);
    chk("s2_first", q_green[s_q], 8'h03);
    chk("s2_second", q_green[s_q+1], 8'hC0);
    chk("s2_allred_cycles", cnt_red - s_red, 4);
    chk("s2_load_pulses", cnt_load - s_load, 1);

    // group 2 granted, then groups 0 and 3 request during its green
`ifdef EMERGENCY_FIXED_PRIO_EN
    rr_second = 8'h03; rr_third = 8'hC0;
`else
    rr_second = 8'hC0; rr_third = 8'h03;
`endif
    do_reset(2);
    snap();
    pulse(8'h10);
    wait_green(100);
    cyc(3);
    pulse(8'h82);
    wait_quiet(1000);
    chk("s3_first", q_green[s_q], 8'h30);
    chk("s3_second", q_green[s_q+1], rr_second);
    chk("s3_third", q_green[s_q+2], rr_third);
    chk("s3_load_pulses", cnt_load - s_load, 1);

    // held request served exactly once
    do_reset(2);
    snap();
    bus.emergencyLane = 8'h02;
    wait_quiet(500);
    cyc(40);
    chk("s4_green_cycles", cnt_green - s_green, 20);
    chk("s4_grants", q_green.size() - s_q, 1);
    chk("s4_load_pulses", cnt_load - s_load, 1);
    bus.emergencyLane = 8'd0;
    cyc(2);

    // tick every 4th cycle: green stretches to 80 cycles
    tick_mode = 1;
    do_reset(2);
    snap();
    pulse(8'h20);
    wait_quiet(2000);
    chk("s5_green_cycles", cnt_green - s_green, 80);
    chk("s5_yellow_cycles", cnt_yel - s_yel, 20);

    // reset mid-green with the request still held
    bus.emergencyLane = 8'h20;
    wait_green(500);
    cyc(10);
    reset = 1'b1;
    cyc(1);
    chk("midrst_green", bus.laneGreen, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_group", bus.activeGroup, 0);
    reset = 1'b0;
    snap();
    wait_quiet(2000);
    chk("s6_reserve_green", cnt_green - s_green, 80);
    chk("s6_reserve_group", q_green[s_q], 8'h30);
    bus.emergencyLane = 8'd0;

    // randomized traffic with random tick and sparse resets
    tick_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        bus.emergencyLane = bus.emergencyLane ^ (8'h01 << $urandom_range(0, 7));
      reset = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    reset = 1'b0;
    bus.emergencyLane = 8'd0;
    tick_mode = 0;
    wait_quiet(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
